fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the control decoder in the single-cycle core. It owns the program counter, fetches instructions over a valid/ack handshake to instruction memory, and holds the current instruction stable for the decoder and datapath. It then commits the next PC from the branch, jump and zero results fed back from that instruction's decode and execute. A small FSM sequences reset, fetch, execute-hold and a halt-on-misaligned-target condition.

---
 rtl/core_defs.sv | 23 ++
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit_pc_next.sv | 44 ++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_defs.sv
// rtl/core_defs.sv - shared constants, fetch FSM states and PC source selects
package core_defs;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEQ = 2'd0,
        REL = 2'd1,
        REG = 2'd2
    } pc_src_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/ack bus
interface fetch_unit_if;
    logic                       imem_req;
    logic [core_defs::XLEN-1:0] imem_addr;
    logic                       imem_ack;
    logic [31:0]                imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// rtl/fetch_unit_pc_next.sv - combinational next-PC select and alignment check
module pc_next
    import core_defs::*;
(
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm_ext,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic            i_branch,
    input  logic            i_jump,
    input  logic            i_jalr,
    input  logic            i_zero,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_taken,
    output logic            o_misaligned
);
    logic [XLEN-1:0] w_rel_target;
    logic [XLEN-1:0] w_reg_sum;
    pc_src_t         w_src;

    assign o_pc_plus4   = i_pc + XLEN'(4);
    assign w_rel_target = i_pc + i_imm_ext;
    assign w_reg_sum    = i_rs1_data + i_imm_ext;
    assign o_taken      = (i_branch & i_zero) | i_jump;

    always_comb begin
        w_src = SEQ;
        if (o_taken) begin
            w_src = i_jalr ? REG : REL;
        end
    end

    // JALR drops bit 0 before the alignment check, so only bit 1 can fault it.
    always_comb begin
        o_next_pc = o_pc_plus4;
        case (w_src)
            REL:     o_next_pc = w_rel_target;
            REG:     o_next_pc = {w_reg_sum[XLEN-1:1], 1'b0};
            default: o_next_pc = o_pc_plus4;
        endcase
    end

    assign o_misaligned = o_taken & ~is_word_aligned(o_next_pc);
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, instruction fetch handshake and hold for decode
module fetch_unit
    import core_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_branch,
    input  logic              i_jump,
    input  logic              i_jalr,
    input  logic              i_zero,
    input  logic [XLEN-1:0]   i_imm_ext,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic              i_stall,
    fetch_unit_if.master      imem,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_pc_plus4,
    output logic [31:0]       o_instr,
    output logic              o_instr_valid,
    output logic              o_misalign_err
);
    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_imem_req;
    logic            r_misalign_err;

    logic [XLEN-1:0] w_next_pc;
    logic            w_taken;
    logic            w_misaligned;
    logic            w_capture;
    logic            w_commit;
    logic            w_halt_set;
    logic            w_instr_valid;

    pc_next u_pc_next (
        .i_pc         (r_pc),
        .i_imm_ext    (i_imm_ext),
        .i_rs1_data   (i_rs1_data),
        .i_branch     (i_branch),
        .i_jump       (i_jump),
        .i_jalr       (i_jalr),
        .i_zero       (i_zero),
        .o_next_pc    (w_next_pc),
        .o_pc_plus4   (o_pc_plus4),
        .o_taken      (w_taken),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = FETCH;
            FETCH:   if (imem.imem_ack) w_next_state = EXEC;
            EXEC:    if (!i_stall) w_next_state = w_misaligned ? HALT : FETCH;
            HALT:    w_next_state = HALT;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_capture     = 1'b0;
        w_commit      = 1'b0;
        w_halt_set    = 1'b0;
        w_instr_valid = 1'b0;
        case (r_state)
            FETCH: w_capture = imem.imem_ack;
            EXEC: begin
                w_instr_valid = 1'b1;
                w_commit      = ~i_stall & ~w_misaligned;
                w_halt_set    = ~i_stall & w_misaligned;
            end
            default: ;
        endcase
    end

    // Request is registered from the next state so it is high exactly in FETCH cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_instr        <= NOP_INSTR;
            r_imem_req     <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_imem_req <= (w_next_state == FETCH);
            if (w_capture)  r_instr        <= imem.imem_rdata;
            if (w_commit)   r_pc           <= w_next_pc;
            if (w_halt_set) r_misalign_err <= 1'b1;
        end
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_pc;
    assign o_pc           = r_pc;
    assign o_instr        = r_instr;
    assign o_instr_valid  = w_instr_valid;
    assign o_misalign_err = r_misalign_err;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;
    import core_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch, jump, jalr, zero, stall;
    logic [31:0] imm_ext, rs1_data;
    logic [31:0] pc, pc_plus4, instr;
    logic        instr_valid, misalign_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .i_branch       (branch),
        .i_jump         (jump),
        .i_jalr         (jalr),
        .i_zero         (zero),
        .i_imm_ext      (imm_ext),
        .i_rs1_data     (rs1_data),
        .i_stall        (stall),
        .imem           (bus.master),
        .o_pc           (pc),
        .o_pc_plus4     (pc_plus4),
        .o_instr        (instr),
        .o_instr_valid  (instr_valid),
        .o_misalign_err (misalign_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        branch = 0; jump = 0; jalr = 0; zero = 0; stall = 0;
        imm_ext = $urandom; rs1_data = $urandom;
        bus.imem_ack = 0; bus.imem_rdata = $urandom;
    endtask

    // Target computed straight from the ISA rules on plain integers.
    function automatic void model(input logic [31:0] cur, input bit br, j, jr, z,
                                  input logic [31:0] imm, rs1,
                                  output logic [31:0] tgt, output bit mis);
        bit taken = (br && z) || j;
        if (!taken)   tgt = cur + 32'd4;
        else if (jr)  begin tgt = rs1 + imm; if (tgt % 2 == 1) tgt = tgt - 32'd1; end
        else          tgt = cur + imm;
        mis = taken && (tgt % 4 != 0);
    endfunction

    // Entered in a FETCH cycle; leaves in the next FETCH cycle (or HALT).
    task automatic run_instr(input string name, input logic [31:0] w, input int delay,
                             input int nstall, input bit br, j, jr, z,
                             input logic [31:0] imm, rs1, output bit halted);
        logic [31:0] tgt;
        bit          mis;
        for (int d = 0; d < delay; d++) begin
            bus.imem_ack = 0;
            tick();
            n_checks++;
            if ({bus.imem_req, bus.imem_addr, instr_valid} !== {1'b1, exp_pc, 1'b0}) begin
                n_fail++;
                $display("FAIL %s ack_wait: req/addr/valid got %b/%h/%b exp 1/%h/0", name, bus.imem_req, bus.imem_addr, instr_valid, exp_pc);
            end
        end
        bus.imem_ack = 1; bus.imem_rdata = w;
        tick();
        bus.imem_ack = 0; bus.imem_rdata = $urandom;
        n_checks++;
        if ({instr_valid, instr, pc, pc_plus4, bus.imem_req} !== {1'b1, w, exp_pc, exp_pc + 32'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL %s exec: valid/instr/pc/pc4/req got %b/%h/%h/%h/%b exp 1/%h/%h/%h/0", name, instr_valid, instr, pc, pc_plus4, bus.imem_req, w, exp_pc, exp_pc + 32'd4);
        end
        branch = br; jump = j; jalr = jr; zero = z; imm_ext = imm; rs1_data = rs1;
        stall = (nstall > 0);
        for (int s = 0; s < nstall; s++) begin
            bus.imem_ack = 1'($urandom);
            tick();
            n_checks++;
            if ({instr_valid, instr, pc, bus.imem_req} !== {1'b1, w, exp_pc, 1'b0}) begin
                n_fail++;
                $display("FAIL %s stall: valid/instr/pc/req got %b/%h/%h/%b exp 1/%h/%h/0", name, instr_valid, instr, pc, bus.imem_req, w, exp_pc);
            end
        end
        stall = 0; bus.imem_ack = 0;
        model(exp_pc, br, j, jr, z, imm, rs1, tgt, mis);
        tick();
        halted = mis;
        if (!mis) exp_pc = tgt;
        n_checks++;
        if (mis && ({misalign_err, bus.imem_req, instr_valid, pc} !== {1'b1, 1'b0, 1'b0, exp_pc})) begin
            n_fail++;
            $display("FAIL %s halt: err/req/valid/pc got %b/%b/%b/%h exp 1/0/0/%h", name, misalign_err, bus.imem_req, instr_valid, pc, exp_pc);
        end else if (!mis && ({misalign_err, bus.imem_req, instr_valid, bus.imem_addr} !== {1'b0, 1'b1, 1'b0, exp_pc})) begin
            n_fail++;
            $display("FAIL %s commit: err/req/valid/addr got %b/%b/%b/%h exp 0/1/0/%h", name, misalign_err, bus.imem_req, instr_valid, bus.imem_addr, exp_pc);
        end
        clear_inputs();
    endtask

    task automatic goto_pc(input logic [31:0] target);
        bit h;
        run_instr("goto", $urandom, 0, 0, 0, 1, 0, 0, target - exp_pc, 0, h);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        n_checks++;
        if ({pc, instr, instr_valid, bus.imem_req, misalign_err} !== {RESET_PC, NOP_INSTR, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: pc/instr/valid/req/err got %h/%h/%b/%b/%b", pc, instr, instr_valid, bus.imem_req, misalign_err);
        end
        tick();
        exp_pc = RESET_PC;
        n_checks++;
        if ({bus.imem_req, bus.imem_addr, instr_valid} !== {1'b1, RESET_PC, 1'b0}) begin
            n_fail++;
            $display("FAIL first_req: req/addr/valid got %b/%h/%b exp 1/%h/0", bus.imem_req, bus.imem_addr, instr_valid, RESET_PC);
        end
    endtask

    task automatic test_first_instr();
        bit h;
        run_instr("first_instr", 32'h0050_0093, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, h);
    endtask

    task automatic test_ack_delay();
        bit h;
        run_instr("ack_delay3", $urandom, 3, 0, 0, 0, 0, 0, 32'h0, 32'h0, h);
    endtask

    task automatic test_branch();
        bit h;
        goto_pc(32'h10);
        run_instr("branch_taken", $urandom, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFF8, 32'h0, h);
        goto_pc(32'h10);
        run_instr("branch_not_taken", $urandom, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, h);
    endtask

    task automatic test_stall();
        bit h;
        run_instr("stall5", $urandom, 1, 5, 0, 1, 0, 0, 32'h40, 32'h0, h);
    endtask

    task automatic test_wrap();
        bit h;
        run_instr("to_top", $urandom, 0, 0, 0, 1, 1, 0, 32'h0, 32'hFFFF_FFFC, h);
        run_instr("wrap", $urandom, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, h);
    endtask

    task automatic test_random();
        bit h;
        for (int i = 0; i < 25; i++) begin
            logic [31:0] imm = 32'($urandom_range(0, 255) * 4) - 32'd512;
            logic [31:0] rs1 = $urandom & 32'hFFFF_FFFC;
            run_instr("random", $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), imm, rs1, h);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit h;
        goto_pc(32'h40);
        bus.imem_ack = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_BEEF;
        n_checks++;
        if ({pc, instr, instr_valid, bus.imem_req, misalign_err} !== {RESET_PC, NOP_INSTR, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_fetch: pc/instr/valid/req/err got %h/%h/%b/%b/%b", pc, instr, instr_valid, bus.imem_req, misalign_err);
        end
        tick();
        bus.imem_ack = 0;
        exp_pc = RESET_PC;
        n_checks++;
        if ({bus.imem_req, bus.imem_addr, instr_valid, instr} !== {1'b1, RESET_PC, 1'b0, NOP_INSTR}) begin
            n_fail++;
            $display("FAIL late_ack_ignored: req/addr/valid/instr got %b/%h/%b/%h", bus.imem_req, bus.imem_addr, instr_valid, instr);
        end
        run_instr("restart", $urandom, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, h);
    endtask

    task automatic test_misalign();
        bit h;
        goto_pc(32'h10);
        run_instr("jalr_misalign", $urandom, 0, 0, 0, 1, 1, 0, 32'h2, 32'h101, h);
        n_checks++;
        if (h !== 1'b1 || exp_pc !== 32'h10) begin
            n_fail++;
            $display("FAIL misalign_model: halted/pc got %b/%h exp 1/00000010", h, exp_pc);
        end
        for (int i = 0; i < 4; i++) begin
            bus.imem_ack = 1; stall = 1'($urandom);
            tick();
            n_checks++;
            if ({misalign_err, bus.imem_req, instr_valid, pc} !== {1'b1, 1'b0, 1'b0, 32'h10}) begin
                n_fail++;
                $display("FAIL halt_hold: err/req/valid/pc got %b/%b/%b/%h exp 1/0/0/00000010", misalign_err, bus.imem_req, instr_valid, pc);
            end
        end
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        n_checks++;
        if ({misalign_err, pc, instr_valid, bus.imem_req} !== {1'b0, RESET_PC, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_reset: err/pc/valid/req got %b/%h/%b/%b", misalign_err, pc, instr_valid, bus.imem_req);
        end
    endtask

    initial begin
        rst = 1;
        test_reset();
        test_first_instr();
        test_ack_delay();
        test_branch();
        test_stall();
        test_wrap();
        test_random();
        test_reset_mid_fetch();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
